// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state type and default sizing
// for the GCD operand sequencer and its pair FIFO.
package gcd_pkg;

  localparam int GCD_WIDTH   = 16;
  localparam int GCD_DEPTH   = 4;
  localparam int GCD_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// gcd_pair_fifo: operand-pair buffer, DEPTH entries of 2*WIDTH bits.
// Ports: clock, reset (async, high), push/wdata in, pop/rdata out
// (rdata shows the head entry), count = occupancy (0..DEPTH).
module gcd_pair_fifo
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int DEPTH = GCD_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [2*WIDTH-1:0]     wdata,
  output logic [2*WIDTH-1:0]     rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  // A push into a full buffer is dropped; pop of empty is a no-op.
  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// gcd_operand_sequencer: buffers operand pairs and feeds them serially
// to a GCD engine (start, a, a, b), then returns result or timeout.
// Ports: clock, reset (async, high); in_valid/in_ready/in_a/in_b;
// gcd_start/gcd_data to engine, gcd_done/gcd_result back;
// out_valid/out_ready/out_gcd/out_err result handshake; busy.
// Option: define GCD_ZERO_BYPASS_EN to answer pairs with a zero
// operand directly (a|b) without using the engine.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = GCD_DEPTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [TW-1:0]      wcnt;
  logic               push;
  logic               pop;

  assign in_ready        = count < CW'(DEPTH);
  assign push            = in_valid && in_ready;
  assign pop             = (state == IDLE) && (count != '0);
  assign {head_a, head_b} = head;
  assign busy            = state != IDLE;

  gcd_pair_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .count (count)
  );

  // Outputs are registered: each is loaded on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      wcnt      <= '0;
      gcd_start <= 1'b0;
      gcd_data  <= '0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            a_r <= head_a;
            b_r <= head_b;
`ifdef GCD_ZERO_BYPASS_EN
            if (head_a == '0 || head_b == '0) begin
              state     <= HOLD;
              gcd_data  <= head_b;
              out_gcd   <= head_a | head_b;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
            end else
`endif
            begin
              state     <= START;
              gcd_start <= 1'b1;
              gcd_data  <= head_a;
            end
          end
        end
        START: begin
          state     <= LOAD_A;
          gcd_start <= 1'b0;
          gcd_data  <= a_r;
        end
        LOAD_A: begin
          state    <= LOAD_B;
          gcd_data <= b_r;
        end
        LOAD_B: begin
          state    <= WAIT;
          gcd_data <= b_r;
          wcnt     <= '0;
        end
        WAIT: begin
          if (gcd_done) begin
            state     <= HOLD;
            out_gcd   <= gcd_result;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
          end else if (wcnt == TW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th WAIT cycle without done.
            state     <= HOLD;
            out_gcd   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            gcd_data  <= '0;
            wcnt      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// tb_gcd_operand_sequencer: directed bench with a small engine model
// that answers in the first WAIT cycle (or never, when disabled).
module tb_gcd_operand_sequencer;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  bit           eng_en = 1'b1;
  int           phase;
  logic [W-1:0] seq [3];
  int           starts = 0;

  gcd_operand_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] euclid(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Engine model: captures start,a,a,b then answers next cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      phase      <= 0;
      gcd_done   <= 1'b0;
      gcd_result <= '0;
    end else begin
      gcd_done <= 1'b0;
      case (phase)
        0: if (gcd_start) begin
          seq[0] <= gcd_data;
          phase  <= 1;
        end
        1: begin
          seq[1] <= gcd_data;
          phase  <= 2;
        end
        2: begin
          seq[2] <= gcd_data;
          phase  <= 0;
          if (eng_en) begin
            gcd_done   <= 1'b1;
            gcd_result <= euclid(seq[1], gcd_data);
          end
        end
        default: phase <= 0;
      endcase
    end
  end

  always @(posedge clock) begin
    if (gcd_start) starts <= starts + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output bit           ok
  );
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    ok = in_ready;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Negedges until out_valid; -1 when the bound expires.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready_busy: got %b%b want 10",
               in_ready, busy);
    end
    vectors++;
    if (gcd_start !== 1'b0 || gcd_data !== '0) begin
      miscompares++;
      $display("FAIL rst_engine: got %b/%0d want 0/0",
               gcd_start, gcd_data);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_gcd !== '0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_out: got %b/%0d/%b want 0/0/0",
               out_valid, out_gcd, out_err);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    int s0 = starts;
    out_ready = 1'b1;
    push(16'd143, 16'd78, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_push: got %b want 1", ok);
    end
    wait_valid(n);
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d want 5", n);
    end
    vectors++;
    if (out_gcd !== 16'd13 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got %0d/%b want 13/0",
               out_gcd, out_err);
    end
    vectors++;
    if (seq[0] !== 16'd143 || seq[1] !== 16'd143 ||
        seq[2] !== 16'd78) begin
      miscompares++;
      $display("FAIL basic_seq: got %0d,%0d,%0d want 143,143,78",
               seq[0], seq[1], seq[2]);
    end
    vectors++;
    if (gcd_data !== 16'd78) begin
      miscompares++;
      $display("FAIL basic_hold_data: got %0d want 78", gcd_data);
    end
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || gcd_data !== '0) begin
      miscompares++;
      $display("FAIL basic_release: got %b/%b/%0d want 0/0/0",
               out_valid, busy, gcd_data);
    end
    vectors++;
    if (starts != s0 + 1) begin
      miscompares++;
      $display("FAIL basic_starts: got %0d want %0d",
               starts - s0, 1);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [W-1:0] exp_q [5];
    exp_q = '{16'd7, 16'd25, 16'd27, 16'd3, 16'd7};
    out_ready = 1'b0;
    push(16'd12, 16'd18, ok);
    wait_valid(n);
    vectors++;
    if (n < 0 || out_gcd !== 16'd6) begin
      miscompares++;
      $display("FAIL b2b_first: got %0d want 6", out_gcd);
    end
    push(16'd35, 16'd49, ok);
    push(16'd100, 16'd75, ok);
    push(16'd81, 16'd27, ok);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready3: got %b want 1", in_ready);
    end
    push(16'd9, 16'd6, ok);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full: got %b want 0", in_ready);
    end
    in_valid = 1'b1;
    in_a = 16'd21;
    in_b = 16'd14;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_gcd !== 16'd6) begin
        miscompares++;
        $display("FAIL b2b_holdoff: got %b/%b/%0d want 0/1/6",
                 in_ready, out_valid, out_gcd);
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    push(16'd21, 16'd14, ok);
    vectors++;
    if (ok !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pop_push: got ok=%b ready=%b want 1/0",
               ok, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      vectors++;
      if (n < 0 || out_gcd !== exp_q[i] || out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_order%0d: got %0d/%b want %0d/0",
                 i, out_gcd, out_err, exp_q[i]);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    eng_en = 1'b0;
    out_ready = 1'b0;
    push(16'd5, 16'd10, ok);
    wait_valid(n);
    vectors++;
    if (n != 1028) begin
      miscompares++;
      $display("FAIL to_latency: got %0d want 1028", n);
    end
    vectors++;
    if (out_err !== 1'b1 || out_gcd !== '0) begin
      miscompares++;
      $display("FAIL to_result: got %0d/%b want 0/1",
               out_gcd, out_err);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL to_hold: got %b/%b/%b want 1/1/1",
               out_valid, out_err, busy);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL to_release: got %b want 0", out_valid);
    end
    eng_en = 1'b1;
  endtask

  task automatic test_zero_bypass();
    bit ok;
    int n;
    int s0 = starts;
    out_ready = 1'b0;
    push(16'd0, 16'd21, ok);
    wait_valid(n);
    vectors++;
    if (out_gcd !== 16'd21 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL zb_result: got %0d/%b want 21/0",
               out_gcd, out_err);
    end
`ifdef GCD_ZERO_BYPASS_EN
    vectors++;
    if (n != 1 || starts != s0) begin
      miscompares++;
      $display("FAIL zb_bypass: got lat %0d starts %0d want 1/0",
               n, starts - s0);
    end
`else
    vectors++;
    if (n != 5 || starts != s0 + 1) begin
      miscompares++;
      $display("FAIL zb_engine: got lat %0d starts %0d want 5/1",
               n, starts - s0);
    end
`endif
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit ok;
    int s0;
    eng_en = 1'b0;
    out_ready = 1'b0;
    push(16'd8, 16'd12, ok);
    push(16'd30, 16'd45, ok);
    repeat (5) @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || gcd_data !== 16'd12) begin
      miscompares++;
      $display("FAIL mid_wait: got %b/%0d want 1/12", busy, gcd_data);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || gcd_data !== '0 || gcd_start !== 1'b0 ||
        out_valid !== 1'b0 || out_gcd !== '0 || out_err !== 1'b0 ||
        in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got b%b d%0d s%b v%b g%0d e%b r%b",
               busy, gcd_data, gcd_start, out_valid, out_gcd,
               out_err, in_ready);
    end
    s0 = starts;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    vectors++;
    if (starts != s0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_discard: got starts %0d busy %b want 0/0",
               starts - s0, busy);
    end
    eng_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_zero_bypass();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
